vend_payout: RTL and testbench
==============================

Name: vend_payout

Overview:
- Downstream end of the vending datapath. Consumes the vending controller's result, which is a product code plus a change amount.
- Emits a one-cycle product-release pulse for the chute.
- Pays out the change one coin at a time over a valid/ack handshake to the coin hopper.
- Keeps per-denomination coin inventory, selects coins greedily, and flags short-change when the inventory cannot cover the amount.

Parameters:
- INIT_CNT, 8: coins of each denomination loaded into inventory at reset (0..255).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- req_valid  in  1  payout request valid.
- req_ready  out  1  block can accept a request; 1 only in IDLE.
- req_item  in  2  product code: 0 = refund only; 1..3 = product.
- req_change  in  8  change to return, unsigned, 0..255.
- drop_pulse  out  1  one-cycle product-release strobe.
- drop_item  out  2  product code; valid while drop_pulse=1, else 0.
- coin_valid  out  1  coin request to hopper.
- coin_type  out  2  denomination: 0 = 1, 1 = 5, 2 = 10, 3 = 50; stable while coin_valid=1.
- coin_ack  in  1  hopper has ejected the requested coin.
- refill_en  in  1  add coins to inventory this cycle.
- refill_type  in  2  denomination to refill.
- refill_cnt  in  8  number of coins added.
- busy  out  1  1 in any state other than IDLE.
- done  out  1  one-cycle strobe at end of transaction.
- short_err  out  1  change could not be fully paid; held until the next accept.
- change_left  out  8  change still owed; 0 on full payout.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - Every inventory counter is set to INIT_CNT.
  - Outputs: req_ready=1; drop_pulse=0; drop_item=0; coin_valid=0; coin_type=0; busy=0; done=0; short_err=0; change_left=0.
  - A reset in the middle of a transaction drops coin_valid in the same instant. No coin is counted, and the request is lost.
- FSM states: IDLE, DROP, SEL, COIN, DONE.
- IDLE:
  - Accept when req_valid=1 and req_ready=1.
  - On accept: latch req_item; load change_left=req_change; clear short_err; go to DROP.
- DROP (exactly 1 cycle):
  - drop_pulse=1 and drop_item=latched item when item≠0.
  - Item 0 gives drop_pulse=0.
  - Always go to SEL next.
- SEL (1 cycle, coin_valid=0):
  - If change_left=0, go to DONE.
  - Otherwise pick the largest denomination d with value(d) ≤ change_left and inv[d] > 0, register coin_type=d, and go to COIN.
  - If no denomination qualifies, set short_err=1 and go to DONE.
- COIN:
  - coin_valid=1 with coin_type held.
  - Wait indefinitely for coin_ack.
  - In the coin_ack cycle: change_left -= value(coin_type); inv[coin_type] -= 1; next state SEL, so coin_valid is low for at least one cycle between coins.
  - coin_ack while coin_valid=0 is ignored.
- DONE (1 cycle): done=1, then return to IDLE.
  - change_left and short_err keep their values until the next accept.
- Latency:
  - Accept at edge T gives drop_pulse in cycle T+1.
  - With zero change, done is asserted in cycle T+3.
  - Each coin costs 1 SEL cycle plus the COIN cycles up to and including coin_ack.
- Inventory arithmetic:
  - Counters are 8-bit.
  - refill_en is honoured in every state. It adds refill_cnt to inv[refill_type], saturating at 255.
  - Refill and decrement of the same denomination in the same cycle both apply: new = sat255(inv + refill_cnt − 1).
  - A decrement is never issued on a zero counter, because SEL excludes it.
- change_left cannot underflow, since only coins with value ≤ change_left are selected.

Test Plan:
1. Full-inventory payout:
   - Stimulus: reset; request item=2, change=67; hopper acks each coin 1 cycle after coin_valid.
   - Required: drop_pulse with drop_item=2 one cycle after accept; coin_type sequence 3, 2, 1, 0, 0 (50, 10, 5, 1, 1); done; change_left=0; short_err=0; inventory 50s=7, 10s=7, 5s=7, 1s=6.
2. Denomination exhausted:
   - Stimulus: set the 50 inventory to 0 by paying out 8 × 50 (change=200, then change=200); then request change=67.
   - Required: coin sequence 10×6, 5, 1, 1; inv[10] decrements to 0 from its prior value as expected.
3. Short change:
   - Stimulus: after reset, drain 5, 10 and 50 to 0 and leave 1s=2; request change=5.
   - Required: two 1-coins, then short_err=1, change_left=3, done pulse.
4. Refund-only, zero change:
   - Stimulus: item=0, change=0, accepted at edge T.
   - Required: no drop_pulse, no coin_valid; done=1 in cycle T+3; req_ready back to 1 in T+4.
5. Hopper stall and refill collision:
   - Stimulus: hold coin_ack low for 10 cycles on a 1-coin while inv[0]=1; in the ack cycle assert refill_en with type 0, cnt=4.
   - Required: coin_type stable for all 10 cycles; inv[0]=4 after the ack; a second refill of 255 saturates at 255.
6. Reset mid-operation:
   - Stimulus: drive rst=0 while in COIN with coin_valid=1.
   - Required: coin_valid=0 immediately (asynchronous); all inventory counters = INIT_CNT; req_ready=1 after rst returns to 1.

Source files
------------

// File: rtl/vend_payout.sv
// Payout stage of the vending datapath: releases the product, then pays change
// one coin at a time using greedy selection over a per-denomination inventory.
module vend_payout #(
  parameter int unsigned INIT_CNT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_item,
  input  logic [7:0] req_change,
  output logic       drop_pulse,
  output logic [1:0] drop_item,
  output logic       coin_valid,
  output logic [1:0] coin_type,
  input  logic       coin_ack,
  input  logic       refill_en,
  input  logic [1:0] refill_type,
  input  logic [7:0] refill_cnt,
  output logic       busy,
  output logic       done,
  output logic       short_err,
  output logic [7:0] change_left
);

  typedef enum logic [2:0] {StIdle, StDrop, StSel, StCoin, StDone} state_e;

  state_e     state_q, state_d;
  logic [1:0] item_q, item_d;
  logic [7:0] change_q, change_d;
  logic       short_q, short_d;
  logic [1:0] type_q, type_d;
  logic       dec_en;

  logic [7:0] inv_q   [4];
  logic [7:0] inv_d   [4];
  logic [8:0] inv_sum [4];

  logic       pick_ok;
  logic [1:0] pick;

  function automatic logic [7:0] coin_value(input logic [1:0] t);
    unique case (t)
      2'd0: coin_value = 8'd1;
      2'd1: coin_value = 8'd5;
      2'd2: coin_value = 8'd10;
      default: coin_value = 8'd50;
    endcase
  endfunction

  // Largest denomination that fits the remaining change and is in stock.
  always_comb begin
    pick_ok = 1'b1;
    pick    = 2'd0;
    if (change_q >= 8'd50 && inv_q[3] != 8'd0) begin
      pick = 2'd3;
    end else if (change_q >= 8'd10 && inv_q[2] != 8'd0) begin
      pick = 2'd2;
    end else if (change_q >= 8'd5 && inv_q[1] != 8'd0) begin
      pick = 2'd1;
    end else if (change_q != 8'd0 && inv_q[0] != 8'd0) begin
      pick = 2'd0;
    end else begin
      pick_ok = 1'b0;
    end
  end

  // Next-state logic for the transaction FSM.
  always_comb begin
    state_d  = state_q;
    item_d   = item_q;
    change_d = change_q;
    short_d  = short_q;
    type_d   = type_q;
    dec_en   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          item_d   = req_item;
          change_d = req_change;
          short_d  = 1'b0;
          state_d  = StDrop;
        end
      end
      StDrop: state_d = StSel;
      StSel: begin
        if (change_q == 8'd0) begin
          state_d = StDone;
        end else if (pick_ok) begin
          type_d  = pick;
          state_d = StCoin;
        end else begin
          short_d = 1'b1;
          state_d = StDone;
        end
      end
      StCoin: begin
        if (coin_ack) begin
          change_d = change_q - coin_value(type_q);
          dec_en   = 1'b1;
          state_d  = StSel;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Inventory update: refill and coin decrement may hit the same counter; saturate at 255.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      inv_sum[i] = {1'b0, inv_q[i]};
      if (refill_en && refill_type == 2'(i)) begin
        inv_sum[i] = inv_sum[i] + {1'b0, refill_cnt};
      end
      if (dec_en && type_q == 2'(i)) begin
        inv_sum[i] = inv_sum[i] - 9'd1;
      end
      inv_d[i] = inv_sum[i][8] ? 8'hff : inv_sum[i][7:0];
    end
  end

  // FSM and transaction registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      item_q   <= 2'd0;
      change_q <= 8'd0;
      short_q  <= 1'b0;
      type_q   <= 2'd0;
    end else begin
      state_q  <= state_d;
      item_q   <= item_d;
      change_q <= change_d;
      short_q  <= short_d;
      type_q   <= type_d;
    end
  end

  // Inventory counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        inv_q[i] <= 8'(INIT_CNT);
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        inv_q[i] <= inv_d[i];
      end
    end
  end

  assign req_ready   = (state_q == StIdle);
  assign busy        = (state_q != StIdle);
  assign drop_pulse  = (state_q == StDrop) && (item_q != 2'd0);
  assign drop_item   = drop_pulse ? item_q : 2'd0;
  assign coin_valid  = (state_q == StCoin);
  assign coin_type   = type_q;
  assign done        = (state_q == StDone);
  assign short_err   = short_q;
  assign change_left = change_q;

endmodule

// File: tb/tb_vend_payout.sv
// Scoreboard bench for vend_payout: a greedy change model predicts drops, coins
// and completions; a negedge monitor pops and compares as the DUT presents them.
module tb_vend_payout;

  localparam int INIT = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_item = 2'd0;
  logic [7:0] req_change = 8'd0;
  logic       drop_pulse;
  logic [1:0] drop_item;
  logic       coin_valid;
  logic [1:0] coin_type;
  logic       coin_ack = 1'b0;
  logic       refill_en;
  logic [1:0] refill_type;
  logic [7:0] refill_cnt;
  logic       busy;
  logic       done;
  logic       short_err;
  logic [7:0] change_left;

  // Refill is driven either by the stimulus (idle refills) or the hopper (collision).
  logic       st_rf_en = 1'b0;
  logic [1:0] st_rf_type = 2'd0;
  logic [7:0] st_rf_cnt = 8'd0;
  logic       hop_rf = 1'b0;
  assign refill_en   = hop_rf | st_rf_en;
  assign refill_type = hop_rf ? 2'd0 : st_rf_type;
  assign refill_cnt  = hop_rf ? 8'd4 : st_rf_cnt;

  vend_payout #(.INIT_CNT(INIT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_item   (req_item),
    .req_change (req_change),
    .drop_pulse (drop_pulse),
    .drop_item  (drop_item),
    .coin_valid (coin_valid),
    .coin_type  (coin_type),
    .coin_ack   (coin_ack),
    .refill_en  (refill_en),
    .refill_type(refill_type),
    .refill_cnt (refill_cnt),
    .busy       (busy),
    .done       (done),
    .short_err  (short_err),
    .change_left(change_left)
  );

  always #5 clk = ~clk;

  typedef struct {int item; int cyc;} drop_t;
  typedef struct {int sh; int left; int cyc;} done_t;

  drop_t drop_q[$];
  int    coin_q[$];
  done_t done_q[$];

  int inv_m [4];
  int val   [4] = '{1, 5, 10, 50};

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int done_cnt = 0;
  int stall = 0;
  bit rand_stall = 1'b0;
  bit collide = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) inv_m[i] = INIT;
  endtask

  task automatic model_refill(input int t, input int c);
    inv_m[t] = (inv_m[t] + c > 255) ? 255 : inv_m[t] + c;
  endtask

  // Whole-transaction prediction: greedy change from the current model inventory.
  task automatic model_txn(input int item, input int change, input int acc_cyc);
    int left;
    int pk;
    bit sh;
    drop_t d;
    done_t e;
    if (item != 0) begin
      d.item = item;
      d.cyc  = acc_cyc;
      drop_q.push_back(d);
    end
    left = change;
    sh   = 1'b0;
    while (left > 0) begin
      pk = -1;
      for (int k = 3; k >= 0; k--) begin
        if (pk < 0 && val[k] <= left && inv_m[k] > 0) pk = k;
      end
      if (pk < 0) begin
        sh = 1'b1;
        break;
      end
      coin_q.push_back(pk);
      inv_m[pk]--;
      left -= val[pk];
    end
    e.sh   = sh;
    e.left = left;
    e.cyc  = (change == 0) ? acc_cyc + 2 : -1;
    done_q.push_back(e);
  endtask

  // Cycle counter, advanced on every rising edge.
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Hopper model: acks each coin after a programmable stall.
  initial forever begin
    int n;
    @(negedge clk);
    if (coin_valid) begin
      n = rand_stall ? int'($urandom_range(0, 3)) : stall;
      repeat (n) @(negedge clk);
      coin_ack = 1'b1;
      hop_rf   = collide;
      @(negedge clk);
      coin_ack = 1'b0;
      hop_rf   = 1'b0;
    end
  end

  // Monitor: pops expectations whenever the DUT presents a drop, coin or done.
  initial begin
    drop_t d;
    done_t e;
    bit    cv_prev;
    bit    rdy_next;
    int    cur_coin;
    cv_prev  = 1'b0;
    rdy_next = 1'b0;
    cur_coin = -1;
    forever begin
      @(negedge clk);
      if (!rst) begin
        cv_prev  = 1'b0;
        rdy_next = 1'b0;
      end else begin
        if (rdy_next) chk("ready_after_done", req_ready, 1);
        rdy_next = 1'b0;
        chk("busy_vs_ready", busy, req_ready ? 0 : 1);
        if (drop_pulse) begin
          if (drop_q.size() == 0) begin
            chk("unexpected_drop", 1, 0);
          end else begin
            d = drop_q.pop_front();
            chk("drop_item", drop_item, d.item);
            chk("drop_cycle", cyc, d.cyc);
          end
        end
        if (coin_valid && !cv_prev) begin
          if (coin_q.size() == 0) begin
            chk("unexpected_coin", 1, 0);
            cur_coin = -1;
          end else begin
            cur_coin = coin_q.pop_front();
          end
        end
        if (coin_valid) chk("coin_type", coin_type, cur_coin);
        cv_prev = coin_valid;
        if (done) begin
          done_cnt++;
          rdy_next = 1'b1;
          if (done_q.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            e = done_q.pop_front();
            chk("short_err", short_err, e.sh);
            chk("change_left", change_left, e.left);
            if (e.cyc >= 0) chk("done_cycle", cyc, e.cyc);
            chk("coins_all_paid", coin_q.size(), 0);
          end
        end
      end
    end
  end

  task automatic issue_req(input int item, input int change);
    for (int i = 0; i < 200 && !req_ready; i++) @(negedge clk);
    if (!req_ready) chk("ready_timeout", 0, 1);
    req_valid  = 1'b1;
    req_item   = 2'(item);
    req_change = 8'(change);
    model_txn(item, change, cyc + 1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic run_txn(input int item, input int change);
    int target;
    target = done_cnt + 1;
    issue_req(item, change);
    for (int i = 0; i < 3000 && done_cnt < target; i++) @(negedge clk);
    if (done_cnt < target) chk("done_timeout", done_cnt, target);
    @(negedge clk);
  endtask

  task automatic refill(input int t, input int c);
    @(negedge clk);
    st_rf_en   = 1'b1;
    st_rf_type = 2'(t);
    st_rf_cnt  = 8'(c);
    @(negedge clk);
    st_rf_en = 1'b0;
    model_refill(t, c);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    drop_q.delete();
    coin_q.delete();
    done_q.delete();
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #1 rst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_drop_pulse", drop_pulse, 0);
    chk("rst_drop_item", drop_item, 0);
    chk("rst_coin_valid", coin_valid, 0);
    chk("rst_coin_type", coin_type, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_short_err", short_err, 0);
    chk("rst_change_left", change_left, 0);
    rst = 1'b1;
    @(negedge clk);

    // Full inventory payout: 50,10,5,1,1.
    stall = 1;
    run_txn(2, 67);

    // Exhaust the 50s, then 10s, 5s and most 1s; end with a short payout.
    do_reset();
    stall = 0;
    run_txn(1, 200);
    run_txn(3, 200);
    run_txn(2, 67);
    run_txn(1, 20);
    run_txn(1, 35);
    run_txn(0, 4);
    run_txn(2, 5);

    // Refund only, zero change: exact done/ready timing.
    run_txn(0, 0);

    // Long hopper stall on the last 1-coin with a refill in the ack cycle.
    refill(0, 1);
    stall   = 10;
    collide = 1'b1;
    run_txn(1, 1);
    collide = 1'b0;
    model_refill(0, 4);
    stall = 0;
    run_txn(0, 5);
    refill(0, 255);
    run_txn(0, 5);

    // Asynchronous reset while a coin is outstanding.
    stall = 40;
    issue_req(3, 67);
    for (int i = 0; i < 100 && !coin_valid; i++) @(negedge clk);
    chk("coin_before_reset", coin_valid, 1);
    #2 rst = 1'b0;
    #1;
    chk("async_coin_valid", coin_valid, 0);
    chk("async_req_ready", req_ready, 1);
    chk("async_change_left", change_left, 0);
    drop_q.delete();
    coin_q.delete();
    done_q.delete();
    model_reset();
    stall = 0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (50) @(negedge clk);
    chk("ready_after_reset", req_ready, 1);
    run_txn(2, 67);

    // Randomised traffic with idle refills and random hopper stalls.
    rand_stall = 1'b1;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        refill(int'($urandom_range(0, 3)),
               ($urandom_range(0, 7) == 0) ? 255 : int'($urandom_range(0, 30)));
      end
      run_txn(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)));
    end
    rand_stall = 1'b0;

    repeat (5) @(negedge clk);
    chk("drop_queue_empty", drop_q.size(), 0);
    chk("coin_queue_empty", coin_q.size(), 0);
    chk("done_queue_empty", done_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
